// File: rtl/adc_cal_sequencer.sv
// Power-down / power-up / calibration sequencer for the ADC macro.
// Drives the triplicated OM/CAL/DF pins and reports ready, done and timeout status.
module adc_cal_sequencer #(
  parameter int PUP_CYC       = 16,
  parameter int CAL_PULSE_CYC = 8,
  parameter int BUSY_RISE_TO  = 64,
  parameter int CAL_TO        = 32768,
  parameter int CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cfg_enable,
  input  logic       cfg_df,
  input  logic       cal_req,
  input  logic       CAL_BUSY,
  output logic       OM_A,
  output logic       OM_B,
  output logic       OM_C,
  output logic       CAL_A,
  output logic       CAL_B,
  output logic       CAL_C,
  output logic       DF_A,
  output logic       DF_B,
  output logic       DF_C,
  output logic       adc_ready,
  output logic       cal_done,
  output logic       cal_err,
  output logic [7:0] cal_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PD        = 3'd0,
    S_PWRUP     = 3'd1,
    S_CAL_PULSE = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_WAIT_FALL = 3'd4,
    S_READY     = 3'd5,
    S_ERROR     = 3'd6
  } st_t;

  localparam logic [CNT_W-1:0] PUP_LAST  = CNT_W'(PUP_CYC - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(BUSY_RISE_TO - 1);
  localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(CAL_TO - 1);

  st_t              st;
  st_t              nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy_p0;
  logic             busy_p1;
  logic             busy_s;
  logic             om_r;
  logic             cal_r;
  logic             df_r;
  logic             cal_complete;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign busy_s = busy_p1;

  always_comb begin
    nxt = st;
    if (!cfg_enable) begin
      nxt = S_PD;
    end else begin
      case (st)
        S_PD:        nxt = S_PWRUP;
        S_PWRUP:     if (cnt == PUP_LAST) nxt = S_WAIT_RISE;
        S_CAL_PULSE: if (cnt == CAL_LAST) nxt = S_WAIT_RISE;
        S_WAIT_RISE: begin
          if (busy_s)                 nxt = S_WAIT_FALL;
          else if (cnt == RISE_LAST)  nxt = S_ERROR;
        end
        S_WAIT_FALL: begin
          if (!busy_s)                nxt = S_READY;
          else if (cnt == FALL_LAST)  nxt = S_ERROR;
        end
        // A request wins over a self-started recalibration seen on busy_s.
        S_READY: begin
          if (cal_req)                nxt = S_CAL_PULSE;
          else if (busy_s)            nxt = S_WAIT_FALL;
        end
        S_ERROR:     if (cal_req) nxt = S_CAL_PULSE;
        default:     nxt = S_PD;
      endcase
    end
  end

  assign cal_complete = (st == S_WAIT_FALL) && (nxt == S_READY);

  // Outputs are decoded from the next state so pins move on the transition edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_p0   <= 1'b0;
      busy_p1   <= 1'b0;
      st        <= S_PD;
      cnt       <= '0;
      om_r      <= 1'b0;
      cal_r     <= 1'b0;
      df_r      <= 1'b0;
      adc_ready <= 1'b0;
      cal_done  <= 1'b0;
      cal_err   <= 1'b0;
      cal_count <= 8'd0;
    end else begin
      busy_p0   <= CAL_BUSY;
      busy_p1   <= busy_p0;
      st        <= nxt;
      cnt       <= (nxt != st) ? '0 : cnt + CNT_W'(1);
      om_r      <= (nxt != S_PD);
      cal_r     <= (nxt == S_CAL_PULSE);
      adc_ready <= (nxt == S_READY);
      cal_done  <= cal_complete;
      if (cal_complete) cal_count <= sat_inc8(cal_count);
      if (nxt == S_PD)         cal_err <= 1'b0;
      else if (nxt == S_ERROR) cal_err <= 1'b1;
      // DF only follows the request while the ADC is powered down.
      if (st == S_PD) df_r <= cfg_df;
    end
  end

  assign OM_A  = om_r;
  assign OM_B  = om_r;
  assign OM_C  = om_r;
  assign CAL_A = cal_r;
  assign CAL_B = cal_r;
  assign CAL_C = cal_r;
  assign DF_A  = df_r;
  assign DF_B  = df_r;
  assign DF_C  = df_r;
  assign state = st;

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// Directed bench for adc_cal_sequencer: power-up, recalibration, timeouts,
// DF hold-off and asynchronous reset, with hand-computed expectations.
module tb_adc_cal_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       cfg_enable;
  logic       cfg_df;
  logic       cal_req;
  logic       CAL_BUSY;
  logic       OM_A, OM_B, OM_C;
  logic       CAL_A, CAL_B, CAL_C;
  logic       DF_A, DF_B, DF_C;
  logic       adc_ready;
  logic       cal_done;
  logic       cal_err;
  logic [7:0] cal_count;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  adc_cal_sequencer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .cfg_enable (cfg_enable),
    .cfg_df     (cfg_df),
    .cal_req    (cal_req),
    .CAL_BUSY   (CAL_BUSY),
    .OM_A       (OM_A),
    .OM_B       (OM_B),
    .OM_C       (OM_C),
    .CAL_A      (CAL_A),
    .CAL_B      (CAL_B),
    .CAL_C      (CAL_C),
    .DF_A       (DF_A),
    .DF_B       (DF_B),
    .DF_C       (DF_C),
    .adc_ready  (adc_ready),
    .cal_done   (cal_done),
    .cal_err    (cal_err),
    .cal_count  (cal_count),
    .state      (state)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] om3();
    return 32'({OM_A, OM_B, OM_C});
  endfunction

  function automatic logic [31:0] cal3();
    return 32'({CAL_A, CAL_B, CAL_C});
  endfunction

  function automatic logic [31:0] df3();
    return 32'({DF_A, DF_B, DF_C});
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_om"},    om3(), 32'd0);
    chk({tag, "_cal"},   cal3(), 32'd0);
    chk({tag, "_df"},    df3(), 32'd0);
    chk({tag, "_rdy"},   32'(adc_ready), 32'd0);
    chk({tag, "_done"},  32'(cal_done), 32'd0);
    chk({tag, "_err"},   32'(cal_err), 32'd0);
    chk({tag, "_cnt"},   32'(cal_count), 32'd0);
  endtask

  initial begin
    int n;
    RST_N      = 1'b1;
    cfg_enable = 1'b0;
    cfg_df     = 1'b0;
    cal_req    = 1'b0;
    CAL_BUSY   = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_reset_vals("rst");
    cyc(2);
    RST_N = 1'b1;
    cyc(1);

    // Power-up with busy rising 20 cycles after OM, falling 1000 later.
    cfg_enable = 1'b1;
    cyc(1);
    chk("pup_state", 32'(state), 32'd1);
    chk("pup_om", om3(), 32'h7);
    cyc(15);
    chk("pup_hold", 32'(state), 32'd1);
    cyc(1);
    chk("wrise_at16", 32'(state), 32'd3);
    chk("no_cal_pulse", cal3(), 32'd0);
    cyc(4);
    CAL_BUSY = 1'b1;
    cyc(2);
    chk("sync_lat_rise", 32'(state), 32'd3);
    cyc(1);
    chk("wfall", 32'(state), 32'd4);
    cyc(997);
    CAL_BUSY = 1'b0;
    cyc(2);
    chk("rdy_early", 32'(adc_ready), 32'd0);
    cyc(1);
    chk("rdy1", 32'(adc_ready), 32'd1);
    chk("rdy1_state", 32'(state), 32'd5);
    chk("done1", 32'(cal_done), 32'd1);
    chk("cnt1", 32'(cal_count), 32'd1);
    cyc(1);
    chk("done1_pulse", 32'(cal_done), 32'd0);

    // Recalibration request from READY.
    cal_req = 1'b1;
    cyc(1);
    cal_req = 1'b0;
    chk("calp_state", 32'(state), 32'd2);
    chk("calp_rdy", 32'(adc_ready), 32'd0);
    n = (cal3() == 32'h7) ? 1 : 0;
    repeat (8) begin
      cyc(1);
      if (cal3() == 32'h7) n++;
    end
    chk("cal_pulse_len", 32'(n), 32'd8);
    chk("calp_to_wrise", 32'(state), 32'd3);
    CAL_BUSY = 1'b1;
    cyc(3);
    chk("recal_wfall", 32'(state), 32'd4);
    CAL_BUSY = 1'b0;
    cal_req  = 1'b1;
    cyc(1);
    cal_req = 1'b0;
    chk("req_ignored", 32'(state), 32'd4);
    cyc(2);
    chk("rdy2_state", 32'(state), 32'd5);
    chk("cnt2", 32'(cal_count), 32'd2);
    cyc(1);
    chk("req_not_queued", 32'(state), 32'd5);

    // DF changes are held off until the next power-down.
    cfg_df = 1'b1;
    cyc(3);
    chk("df_hold", df3(), 32'd0);
    cfg_enable = 1'b0;
    cyc(1);
    chk("pd_state", 32'(state), 32'd0);
    chk("pd_om", om3(), 32'd0);
    chk("pd_rdy", 32'(adc_ready), 32'd0);
    chk("df_pd_entry", df3(), 32'd0);
    cyc(1);
    chk("df_loaded", df3(), 32'h7);

    // Busy never rises: ERROR 16+64 cycles after OM, then recovery.
    cfg_enable = 1'b1;
    cyc(1);
    chk("p3_om", om3(), 32'h7);
    cyc(16);
    chk("p3_wrise", 32'(state), 32'd3);
    cyc(63);
    chk("p3_pre_err", 32'(state), 32'd3);
    chk("p3_pre_errflag", 32'(cal_err), 32'd0);
    cyc(1);
    chk("p3_err_state", 32'(state), 32'd6);
    chk("p3_err_flag", 32'(cal_err), 32'd1);
    chk("p3_err_om", om3(), 32'h7);
    chk("p3_df_kept", df3(), 32'h7);
    cal_req = 1'b1;
    cyc(1);
    cal_req = 1'b0;
    chk("p3_recover", 32'(state), 32'd2);
    chk("p3_recover_cal", cal3(), 32'h7);
    cyc(8);
    chk("p3_wrise2", 32'(state), 32'd3);
    CAL_BUSY = 1'b1;
    cyc(3);
    CAL_BUSY = 1'b0;
    cyc(3);
    chk("p3_rdy", 32'(state), 32'd5);
    chk("p3_err_sticky", 32'(cal_err), 32'd1);
    chk("p3_cnt", 32'(cal_count), 32'd3);
    cfg_enable = 1'b0;
    cyc(1);
    chk("p3_pd_clr_err", 32'(cal_err), 32'd0);

    // Busy stuck high: ERROR CAL_TO cycles after WAIT_FALL entry.
    CAL_BUSY   = 1'b1;
    cfg_enable = 1'b1;
    cyc(17);
    chk("p4_wrise", 32'(state), 32'd3);
    cyc(1);
    chk("p4_wfall", 32'(state), 32'd4);
    cyc(32767);
    chk("p4_pre_to", 32'(state), 32'd4);
    chk("p4_pre_err", 32'(cal_err), 32'd0);
    cyc(1);
    chk("p4_to_state", 32'(state), 32'd6);
    chk("p4_to_err", 32'(cal_err), 32'd1);
    cfg_enable = 1'b0;
    CAL_BUSY   = 1'b0;
    cyc(1);
    chk("p4_pd_state", 32'(state), 32'd0);
    chk("p4_pd_om", om3(), 32'd0);
    chk("p4_pd_err", 32'(cal_err), 32'd0);
    chk("p4_cnt_kept", 32'(cal_count), 32'd3);

    // Unexpected recalibration in READY, then async reset during WAIT_FALL.
    cfg_df     = 1'b0;
    cfg_enable = 1'b1;
    cyc(17);
    CAL_BUSY = 1'b1;
    cyc(3);
    CAL_BUSY = 1'b0;
    cyc(3);
    chk("p6_rdy", 32'(adc_ready), 32'd1);
    chk("p6_cnt", 32'(cal_count), 32'd4);
    CAL_BUSY = 1'b1;
    cyc(3);
    chk("p6_unexp_state", 32'(state), 32'd4);
    chk("p6_unexp_rdy", 32'(adc_ready), 32'd0);
    #2 RST_N = 1'b0;
    #1 chk_reset_vals("arst");
    CAL_BUSY = 1'b0;
    cyc(2);
    RST_N = 1'b1;
    cyc(2);
    chk("post_rst_state", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
